// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, the fetch-buffer entry type and the address
// legality check used by the fetch front end and by the instruction ROM's
// bounds checks.
package fetch_pkg;

    localparam int ADDR_W    = 64;
    localparam int INSTR_W   = 32;
    localparam int IMEM_SIZE = 1024;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // A fetch address is legal when it is word aligned and the whole word
    // lies inside the ROM. For an aligned address, addr+3 never wraps, so
    // "addr+3 < mem_size" is the same as "addr <= mem_size-4".
    function automatic logic imem_legal(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] mem_size);
        logic aligned_s;
        logic in_range_s;
        aligned_s  = (addr[1:0] == 2'b00);
        in_range_s = (mem_size >= ADDR_W'(4)) && (addr <= (mem_size - ADDR_W'(4)));
        return aligned_s && in_range_s;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetch_entry_t between fetch and decode.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   enq, enq_data  write an entry (accepted when not full, or full with deq)
//   deq          pop the head entry (ignored when empty)
//   flush        drop all entries; a same-cycle deq still completes first
//   count        number of valid entries
//   head         entry at the head of the buffer (don't-care when empty)
//   empty, full  derived from count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enq,
    input  fetch_entry_t     enq_data,
    input  logic             deq,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             do_enq_s;
    logic             do_deq_s;

    // Pointer increment that wraps at DEPTH, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : (p + PTR_W'(1));
    endfunction

    assign count = count_r;
    assign empty = (count_r == CNT_W'(0));
    assign full  = (count_r == CNT_W'(DEPTH));
    assign head  = mem_r[rd_ptr_r];

    // Qualify enqueue/dequeue: a full buffer still accepts a write when the
    // head leaves in the same cycle; a flush discards any write.
    always_comb begin
        do_deq_s = deq && !empty;
        do_enq_s = enq && !flush && (!full || do_deq_s);
        case ({do_enq_s, do_deq_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and occupancy state; flush takes effect after the dequeue.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_enq_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_deq_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; contents are only meaningful under count, so no reset.
    always_ff @(posedge clk) begin
        if (do_enq_s) begin
            mem_r[wr_ptr_r] <= enq_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front end.
// Owns the fetch PC, drives it to the combinational instruction ROM, buffers
// {pc, instr} pairs in a small FIFO and hands them to decode over valid/ready.
// Branch redirects flush the buffer and restart at the target; an illegal
// fetch address sets a sticky fault that only reset or a legal redirect clears.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   imem_addr         byte address to the ROM (the fetch PC register)
//   imem_instr        ROM read data for imem_addr, same cycle
//   redirect_valid    take a branch to redirect_target this cycle
//   redirect_target   branch target byte address
//   out_valid         buffer head holds a valid instruction
//   out_ready         decode accepts the head this cycle
//   out_instr, out_pc instruction at the buffer head and its PC
//   fault             sticky fetch-address fault
module instr_fetch #(
    parameter int ADDR_W   = fetch_pkg::ADDR_W,
    parameter int INSTR_W  = fetch_pkg::INSTR_W,
    parameter int MEM_SIZE = fetch_pkg::IMEM_SIZE,
    parameter int DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault
);
    import fetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] MEM_SIZE_A = ADDR_W'(MEM_SIZE);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic              fault_r;
    logic              pc_legal_s;
    logic              tgt_legal_s;
    logic              deq_s;
    logic              room_s;
    logic              enq_s;
    logic [CNT_W-1:0]  count_s;
    logic              empty_s;
    logic              full_s;
    fetch_entry_t      enq_data_s;
    fetch_entry_t      head_s;

    assign imem_addr  = fetch_pc_r;
    assign fault      = fault_r;
    assign out_valid  = !empty_s;
    assign out_instr  = head_s.instr;
    assign out_pc     = head_s.pc;

    // Enqueue decision: room (counting a same-cycle dequeue), legal PC,
    // no standing fault and no redirect.
    always_comb begin
        pc_legal_s       = imem_legal(fetch_pc_r, MEM_SIZE_A);
        tgt_legal_s      = imem_legal(redirect_target, MEM_SIZE_A);
        deq_s            = !empty_s && out_ready;
        room_s           = !full_s || deq_s;
        enq_data_s.pc    = fetch_pc_r;
        enq_data_s.instr = imem_instr;
        if (room_s && pc_legal_s && !fault_r && !redirect_valid) begin
            enq_s = 1'b1;
        end else begin
            enq_s = 1'b0;
        end
    end

    // Fetch PC and sticky fault: reset, then redirect, then sequential fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= '0;
            fault_r    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_target;
            fault_r    <= !tgt_legal_s;
        end else if (enq_s) begin
            fetch_pc_r <= fetch_pc_r + ADDR_W'(4);
        end else if (!pc_legal_s && !fault_r) begin
            fault_r <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .enq      (enq_s),
        .enq_data (enq_data_s),
        .deq      (deq_s),
        .flush    (redirect_valid),
        .count    (count_s),
        .head     (head_s),
        .empty    (empty_s),
        .full     (full_s)
    );

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end for the single-cycle/pipelined ARM datapath. It owns the fetch program counter and drives the byte address into the combinational `instructmem` ROM. It captures the returned 32-bit word together with its PC into a 2-entry buffer, and presents that buffer to decode over a valid/ready handshake. Branch redirects from execute flush the buffer and restart fetch at the new target. Illegal fetch addresses raise a sticky fault.

## Interface
Parameters:
- `ADDR_W`, 64, byte-address width of the PC and the ROM address.
- `INSTR_W`, 32, instruction width.
- `MEM_SIZE`, 1024, ROM size in bytes; must be a power of two.
- `DEPTH`, 2, number of fetch-buffer entries.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_addr`  out  ADDR_W  byte address to the ROM; always equals `fetch_pc` (combinational from the register).
- `imem_instr`  in  INSTR_W  ROM read data, valid in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  take a branch this cycle.
- `redirect_target`  in  ADDR_W  branch target byte address.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  INSTR_W  instruction at the buffer head.
- `out_pc`  out  ADDR_W  PC of `out_instr`.
- `fault`  out  1  sticky fetch-address fault.

## Operation
- **Address legality.** An address is legal iff `addr[1:0]==0` and `addr+3 < MEM_SIZE`.
- **Enqueue.** The buffer enqueues `{fetch_pc, imem_instr}` and sets `fetch_pc <= fetch_pc + 4` when all of the following hold:
  - the buffer has room, i.e. `count<DEPTH`, or `count==DEPTH` with a dequeue this cycle;
  - `fetch_pc` is legal;
  - `fault==0`;
  - `redirect_valid==0`.
- **Dequeue.** A dequeue occurs when `out_valid && out_ready`. The head advances; order is strictly FIFO.
- **Sequential fault.** If `fetch_pc` is illegal and `fault==0` with no redirect, set `fault`. No enqueue occurs and `fetch_pc` holds. Entries already buffered still drain normally.
- **Redirect.** Redirect has the highest priority after reset.
  - A handshake in the same cycle completes (decode owns that instruction).
  - All buffered entries are then flushed and `fetch_pc <= redirect_target`.
  - There is no enqueue in the redirect cycle.
  - `fault <= !legal(redirect_target)`.
  - A legal redirect is the only way, besides reset, to clear `fault`.
- **While `fault==1`.**
  - Nothing is enqueued.
  - `out_valid` falls once the buffer drains; after an illegal redirect it is 0 immediately.
- **Arithmetic.** PC increment is an unsigned ADDR_W add that wraps silently. Overflow cannot occur in practice because the legality check stops fetch first.
- **Reset.** `fetch_pc=0`, buffer empty, `count=0`, `fault=0`.
  - Reset wins over a simultaneous redirect.
  - Reset mid-operation discards all buffered entries.

## Timing
- **Reset values.**
  - `imem_addr=0`, `out_valid=0`, `fault=0`.
  - `out_instr` and `out_pc` are don't-care while `out_valid=0`; the bench must not check them then.
- **Startup.** First edge after `reset` deasserts enqueues PC 0, so `out_valid=1` with `out_pc=0` in the next cycle.
- **Throughput.** With `out_ready` held 1: one instruction per cycle, PCs consecutive by 4.
- **Redirect latency.**
  - Redirect sampled at edge N: `imem_addr=target` after N.
  - Enqueue at edge N+1.
  - `out_valid` with `out_pc=target` after N+1, i.e. two cycles from the redirect cycle.
  - `out_valid=0` during the intervening cycle.
- **Backpressure.** With `out_ready=0` the buffer fills to DEPTH and `imem_addr` holds at the next unfetched PC.
- **Full buffer.** Simultaneous enqueue and dequeue at `count==DEPTH` is allowed with no bubble.
- **Output stability.** Outputs are registered buffer state. `out_instr` and `out_pc` stay stable while `out_valid && !out_ready`.

## Structure
- **Package `fetch_pkg`.**
  - Constants `ADDR_W`, `INSTR_W`, `IMEM_SIZE`.
  - `typedef struct packed {logic [ADDR_W-1:0] pc; logic [INSTR_W-1:0] instr;} fetch_entry_t`.
  - Function `imem_legal(addr)`, shared with the ROM's bounds checks.
- **Sub-module `fetch_fifo`.**
  - Parameterized DEPTH, circular buffer of `fetch_entry_t`.
  - Ports: `enq`, `deq`, `flush`, `count`.
  - Full/empty are derived from `count`.
  - Priority: flush after deq. Flush clears pointers and count.
- **Top level.** Holds `fetch_pc`, `fault`, and the enqueue/redirect priority logic.

## Test plan
- **Startup stream.** ROM words = index (word at address 4k holds k). Release reset with `out_ready=1` -> cycles 1,2,3 show `out_pc`=0,4,8 and `out_instr`=0,1,2 with `out_valid=1` continuously.
- **Backpressure.** `out_ready=0` for 5 cycles after reset -> `count=2` holding PCs 0,4 and `imem_addr=8`. Raise `out_ready` -> 0,4,8,12 delivered in order, no loss or duplication.
- **Redirect on full buffer.** With the buffer full, pulse `redirect_valid`, target 0x40 -> next cycle `out_valid=0`, `imem_addr=0x40`. Following cycle `out_pc=0x40`, `out_instr=16`.
- **Illegal then legal redirect.**
  - Redirect to 0x42 -> `fault=1` and `out_valid=0` next cycle; `imem_addr` holds 0x42 for 4 cycles.
  - Then redirect to 0x10 -> `fault=0` next cycle, `out_pc=0x10` two cycles after the redirect.
- **End of memory.** Redirect to 0x3F8 with `out_ready=1` -> PCs 0x3F8 and 0x3FC are delivered. Then `fault=1`, and PC 0x400 never appears.
- **Reset mid-operation.** Assert `reset` for one cycle with the buffer full and the same-cycle redirect to 0x80 -> next cycle `out_valid=0`, `fault=0`, `imem_addr=0`. The first output after release is PC 0.
